irq_ctrl_gen: RTL and testbench
===============================

// Module: irq_ctrl_gen
// PURPOSE
// Parametrised interrupt controller for the SM83-style core. Holds the IE and
// IF registers, detects source events (edge or level per bit), keeps IME with
// a delayed EI, arbitrates by fixed priority (bit 0 highest) and runs a
// request/acknowledge dispatch FSM that outputs the vector. Sits between the
// peripheral IRQ lines and the core sequencer, decoded on the internal bus.
// PARAMETERS
// NUM_IRQ    8        sources, 1..8; IE/IF bits [7:NUM_IRQ] unimplemented
// EDGE_MASK  8'hFF    per source: 1 = rising-edge detect, 0 = level (sets IF while high)
// IE_ADDR    16'hFFFF IE register address
// IF_ADDR    16'hFF0F IF register address
// VEC_BASE   16'h0040 vector of source 0
// VEC_SHIFT  3        vector = VEC_BASE + (n << VEC_SHIFT)
// PORTS
// CLK        in   1        single system clock, all state on rising edge
// nRES       in   1        asynchronous, active-low reset
// A          in   16       bus address
// DIN        in   8        write data
// DOUT       out  8        read data, valid same cycle as RD with address hit
// RD         in   1        read strobe
// WR         in   1        write strobe, one-cycle pulse
// SEL        out  1        1 when A equals IE_ADDR or IF_ADDR
// TRIG       in   NUM_IRQ  raw source lines from peripherals
// EI         in   1        EI executed (one-cycle pulse)
// DI         in   1        DI executed (one-cycle pulse)
// RETI       in   1        RETI executed (one-cycle pulse)
// INSTR_END  in   1        instruction-boundary pulse from sequencer
// IRQ_ACK    in   1        core accepts request (one-cycle pulse)
// IRQ_REQ    out  1        dispatch request to core
// WAKE       out  1        (IE & IF) != 0, independent of IME, for HALT/STOP exit
// VEC        out  16       dispatch vector, valid with VEC_VALID
// VEC_VALID  out  1        one-cycle vector strobe
// ACK_ONEHOT out  NUM_IRQ  one-hot of dispatched source, valid with VEC_VALID
// BEHAVIOUR
// - Reset (nRES=0, async): IE=0, IF=0, IME=0, ime_pend=0, trig_q=0, FSM=IDLE;
//   IRQ_REQ=0, VEC_VALID=0, VEC=0, ACK_ONEHOT=0, WAKE=0; DOUT=8'hFF.
// - Reads are combinational: IE reads IE with unimplemented bits as 0; IF reads
//   bits [7:NUM_IRQ] as 1 (IF[7:5]=1 at NUM_IRQ=5). No hit -> DOUT=8'hFF.
// - Writes land on the next clock edge; unimplemented bits are discarded.
// - Event n: edge mode TRIG[n]&~trig_q[n] (trig_q = TRIG registered); level mode TRIG[n].
// - IF next = (WR to IF ? DIN : IF) | event & ~clr; an event beats a CPU write of 0
//   on the same bit in the same cycle; clr (dispatch) beats both.
// - IME: DI clears IME and ime_pend at once; EI sets ime_pend; IME=1 on the
//   first INSTR_END after the EI cycle (EI+INSTR_END same cycle does not count);
//   RETI sets IME next edge, clears ime_pend. DI wins over EI/RETI if simultaneous.
// - pending = IE & IF; WAKE = |pending, registered (1 cycle after IF/IE update).
// - FSM IDLE: IME & |pending -> REQ. REQ: IRQ_REQ=1; IRQ_ACK -> DISP; DI or
//   IME=0 without ACK -> IDLE. DISP (1 cycle): winner = lowest set bit of
//   pending sampled in DISP, not at request time; clear its IF bit, IME=0,
//   VEC_VALID=1, ACK_ONEHOT=winner, VEC per formula -> IDLE.
// - Cancel: pending==0 in DISP (IE/IF cleared after ACK) -> VEC=16'h0000,
//   ACK_ONEHOT=0, VEC_VALID=1, IME still cleared, no IF change.
// - Dispatch latency: IDLE->REQ 1 cycle; ACK->VEC_VALID 1 cycle.
// - No re-request while IME=0; REQ is never held through DISP.
// - nRES asserted mid-dispatch aborts immediately to reset values.
// TESTING
// - Reset: drive nRES=0 mid-REQ -> all outputs reset values, read IF=8'hE0 (NUM_IRQ=5).
// - Write IE=8'h1F, pulse TRIG[2] edge with IME=1 -> IF=8'h04, IRQ_REQ next cycle,
//   ACK -> VEC=16'h0050, ACK_ONEHOT=5'b00100, IF bit2 cleared, IME=0.
// - IF=8'h0A, IE=8'hFF, IME=1 -> first dispatch VEC=16'h0048; after RETI second
//   dispatch VEC=16'h0058.
// - EI then INSTR_END same cycle -> IME stays 0; next INSTR_END -> IME=1, request.
// - In REQ write IE=0 same cycle as IRQ_ACK -> DISP gives VEC=16'h0000, VEC_VALID=1.
// - TRIG[1] rising edge same cycle as WR IF=8'h00 -> IF reads 8'hE2; level-mode
//   bit held high re-sets IF each cycle after dispatch clear.

Source files
------------

// File: rtl/irq_ctrl_gen.sv
// Interrupt controller: IE/IF registers, per-source edge/level detection, IME with
// delayed EI, fixed-priority arbitration (bit 0 highest) and a request/ack dispatch FSM.
module irq_ctrl_gen #(
  parameter int          NUM_IRQ   = 8,
  parameter logic [7:0]  EDGE_MASK = 8'hFF,
  parameter logic [15:0] IE_ADDR   = 16'hFFFF,
  parameter logic [15:0] IF_ADDR   = 16'hFF0F,
  parameter logic [15:0] VEC_BASE  = 16'h0040,
  parameter int          VEC_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        a,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               rd,
  input  logic               wr,
  output logic               sel,
  input  logic [NUM_IRQ-1:0] trig,
  input  logic               ei,
  input  logic               di,
  input  logic               reti,
  input  logic               instr_end,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic               wake,
  output logic [15:0]        vec,
  output logic               vec_valid,
  output logic [NUM_IRQ-1:0] ack_onehot
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DISP = 2'd2
  } state_t;

  state_t state;

  logic [NUM_IRQ-1:0] ie;
  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] trig_q;
  logic               ime;
  logic               ime_pend;

  logic               hit_ie;
  logic               hit_if;
  logic               wr_ie;
  logic               wr_if;
  logic               dispatch;
  logic [NUM_IRQ-1:0] ev;
  logic [NUM_IRQ-1:0] ie_nxt;
  logic [NUM_IRQ-1:0] if_base;
  logic [NUM_IRQ-1:0] if_nxt;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [NUM_IRQ-1:0] win_oh;
  logic [15:0]        win_idx;
  logic [15:0]        vec_nxt;
  logic [7:0]         rd_ie;
  logic [7:0]         rd_if;

  // ---------------------------------------------------------------------------
  // Bus decode and combinational read-back
  // ---------------------------------------------------------------------------
  assign hit_ie = (a == IE_ADDR);
  assign hit_if = (a == IF_ADDR);
  assign sel    = hit_ie | hit_if;
  assign wr_ie  = wr & hit_ie;
  assign wr_if  = wr & hit_if;

  // Unimplemented IE bits read as 0, unimplemented IF bits read as 1.
  // NOTE: always_comb uses blocking (=) assignments; sequential state uses non-blocking (<=).
  always_comb begin
    rd_ie = 8'h00;
    rd_if = 8'hFF;
    for (int i = 0; i < NUM_IRQ; i++) begin
      rd_ie[i] = ie[i];
      rd_if[i] = if_q[i];
    end
    dout = 8'hFF;
    if (rd && hit_ie) begin
      dout = rd_ie;
    end else if (rd && hit_if) begin
      dout = rd_if;
    end
  end

  // ---------------------------------------------------------------------------
  // Source events and next-state IE/IF
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) begin
      ev[i] = EDGE_MASK[i] ? (trig[i] & ~trig_q[i]) : trig[i];
    end
  end

  assign dispatch = (state == ST_REQ) && irq_ack;
  assign ie_nxt   = wr_ie ? din[NUM_IRQ-1:0] : ie;
  assign if_base  = (wr_if ? din[NUM_IRQ-1:0] : if_q) | ev;
  assign pend     = ie & if_q;

  // Arbitration looks at pending as it will stand once the ACK edge lands, so an
  // IE/IF write in the ACK cycle is honoured and can cancel the dispatch.
  assign pend_nxt = ie_nxt & if_base;

  // NOTE: every signal written in this block gets a default first so no latch is inferred.
  always_comb begin
    win_oh  = '0;
    win_idx = 16'h0000;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_nxt[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_idx   = 16'(i);
      end
    end
  end

  assign vec_nxt = (|pend_nxt) ? (VEC_BASE + (win_idx << VEC_SHIFT)) : 16'h0000;

  // Dispatch clear beats both the source event and a CPU write on the same bit.
  assign if_nxt = dispatch ? (if_base & ~win_oh) : if_base;

  // ---------------------------------------------------------------------------
  // IE / IF / source history / WAKE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie     <= '0;
      if_q   <= '0;
      trig_q <= '0;
      wake   <= 1'b0;
    end else begin
      ie     <= ie_nxt;
      if_q   <= if_nxt;
      trig_q <= trig;
      wake   <= |pend;
    end
  end

  // ---------------------------------------------------------------------------
  // Master enable: EI takes effect at the first instruction boundary after it
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ime      <= 1'b0;
      ime_pend <= 1'b0;
    end else if (di) begin
      ime      <= 1'b0;
      ime_pend <= 1'b0;
    end else begin
      if (reti) begin
        ime      <= 1'b1;
        ime_pend <= 1'b0;
      end else begin
        if (ime_pend && instr_end) begin
          ime <= 1'b1;
        end
        if (ei) begin
          ime_pend <= 1'b1;
        end else if (instr_end) begin
          ime_pend <= 1'b0;
        end
      end
      // Accepting an interrupt always drops IME, overriding a same-cycle RETI.
      if (dispatch) begin
        ime <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      irq_req    <= 1'b0;
      vec_valid  <= 1'b0;
      vec        <= 16'h0000;
      ack_onehot <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ime && (|pend)) begin
            state   <= ST_REQ;
            irq_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state      <= ST_DISP;
            irq_req    <= 1'b0;
            vec_valid  <= 1'b1;
            vec        <= vec_nxt;
            ack_onehot <= win_oh;
          end else if (di || !ime) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
          end
        end
        ST_DISP: begin
          state      <= ST_IDLE;
          vec_valid  <= 1'b0;
          vec        <= 16'h0000;
          ack_onehot <= '0;
        end
        default: begin
          state      <= ST_IDLE;
          irq_req    <= 1'b0;
          vec_valid  <= 1'b0;
          vec        <= 16'h0000;
          ack_onehot <= '0;
        end
      endcase
    end
  end

  // Structural invariants of the dispatch handshake.
  a_strobe_single : assert property (@(posedge clk) disable iff (!rst_n) vec_valid |=> !vec_valid);
  a_req_not_disp  : assert property (@(posedge clk) disable iff (!rst_n) !(irq_req && vec_valid));
  a_ack_onehot0   : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_onehot));

endmodule

// File: tb/tb_irq_ctrl_gen.sv
// Self-checking bench for irq_ctrl_gen (5 sources, source 4 level-sensitive):
// directed scenario tasks plus randomized traffic against a behavioural model.
module tb_irq_ctrl_gen;

  localparam int         NI    = 5;
  localparam logic [7:0] EMASK = 8'hEF;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        wr;
  logic        sel;
  logic [NI-1:0] trig;
  logic        ei;
  logic        di;
  logic        reti;
  logic        instr_end;
  logic        irq_ack;
  logic        irq_req;
  logic        wake;
  logic [15:0] vec;
  logic        vec_valid;
  logic [NI-1:0] ack_onehot;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  irq_ctrl_gen #(.NUM_IRQ(NI), .EDGE_MASK(EMASK)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .din(din), .dout(dout), .rd(rd), .wr(wr),
    .sel(sel), .trig(trig), .ei(ei), .di(di), .reti(reti), .instr_end(instr_end),
    .irq_ack(irq_ack), .irq_req(irq_req), .wake(wake), .vec(vec),
    .vec_valid(vec_valid), .ack_onehot(ack_onehot)
  );

  // ---------------------------------------------------------------------------
  // Behavioural reference: applies the controller's rules once per clock edge.
  // ---------------------------------------------------------------------------
  logic [NI-1:0] m_ie, m_if, m_trig_prev, m_ack;
  logic          m_ime, m_ei_wait, m_requesting, m_strobe, m_wake;
  logic [15:0]   m_vec;
  logic [NI-1:0] t_fired, t_ie, t_if, t_pend;
  logic          t_old_ime, t_old_strobe, t_old_pending, t_take;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ie = '0; m_if = '0; m_trig_prev = '0; m_ack = '0;
      m_ime = 0; m_ei_wait = 0; m_requesting = 0; m_strobe = 0; m_wake = 0;
      m_vec = 16'h0000;
    end else begin
      t_old_ime     = m_ime;
      t_old_strobe  = m_strobe;
      t_old_pending = (m_ie & m_if) != 0;
      m_wake        = t_old_pending;
      for (int n = 0; n < NI; n++)
        t_fired[n] = EMASK[n] ? (trig[n] && !m_trig_prev[n]) : trig[n];
      m_trig_prev = trig;
      t_ie = (wr && a == 16'hFFFF) ? din[NI-1:0] : m_ie;
      t_if = ((wr && a == 16'hFF0F) ? din[NI-1:0] : m_if) | t_fired;
      t_take   = m_requesting && irq_ack;
      m_strobe = t_take;
      m_vec    = 16'h0000;
      m_ack    = '0;
      if (t_take) begin
        t_pend = t_ie & t_if;
        for (int n = NI - 1; n >= 0; n--)
          if (t_pend[n]) begin
            m_vec = 16'h0040 + 16'(n * 8);
            m_ack = 5'(1 << n);
          end
        t_if = t_if & ~m_ack;
      end
      if (m_requesting) m_requesting = !irq_ack && !di && t_old_ime;
      else              m_requesting = !t_old_strobe && t_old_ime && t_old_pending;
      if (di) begin
        m_ime = 0; m_ei_wait = 0;
      end else if (reti) begin
        m_ime = 1; m_ei_wait = 0;
      end else begin
        if (m_ei_wait && instr_end) m_ime = 1;
        if (ei) m_ei_wait = 1;
        else if (instr_end) m_ei_wait = 0;
      end
      if (t_take) m_ime = 0;
      m_ie = t_ie;
      m_if = t_if;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    a = addr; din = data; wr = 1'b1;
    tick();
    wr = 1'b0; a = 16'h0000; din = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
    a = addr; rd = 1'b1;
    #1 data = dout;
    rd = 1'b0; a = 16'h0000;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic wait_req(input int budget, input string what);
    int k = 0;
    while (!irq_req && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (irq_req !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: irq_req=%b after %0d cycles, required 1", what, irq_req, k);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] r;
    a = 16'h0000; din = 8'h00; rd = 0; wr = 0; trig = '0;
    ei = 0; di = 0; reti = 0; instr_end = 0; irq_ack = 0;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({irq_req, wake, vec_valid, vec, ack_onehot, dout} !== {3'b000, 16'h0000, 5'b00000, 8'hFF}) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b %b %b %h %b %h, required 0 0 0 0000 00000 ff",
               irq_req, wake, vec_valid, vec, ack_onehot, dout);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_read(16'hFF0F, r);
    n_cmp++;
    if (r !== 8'hE0) begin n_bad++; $display("FAIL reset_if_read: got %h, required e0", r); end
    bus_read(16'hFFFF, r);
    n_cmp++;
    if (r !== 8'h00) begin n_bad++; $display("FAIL reset_ie_read: got %h, required 00", r); end
    bus_read(16'h1234, r);
    n_cmp++;
    if (r !== 8'hFF) begin n_bad++; $display("FAIL nohit_read: got %h, required ff", r); end
    a = 16'hFF0F; #1;
    n_cmp++;
    if (sel !== 1'b1 || dout !== 8'hFF) begin
      n_bad++; $display("FAIL sel_hit_no_rd: sel=%b dout=%h, required 1 ff", sel, dout);
    end
    a = 16'hFF0E; #1;
    n_cmp++;
    if (sel !== 1'b0) begin n_bad++; $display("FAIL sel_miss: sel=%b, required 0", sel); end
    a = 16'h0000;
  endtask

  task automatic test_edge_dispatch();
    logic [7:0] r;
    bus_write(16'hFFFF, 8'h1F);
    bus_write(16'hFF0F, 8'h00);
    pulse_reti();
    trig = 5'b00100;
    tick();
    trig = '0;
    bus_read(16'hFF0F, r);
    n_cmp++;
    if (r !== 8'hE4) begin n_bad++; $display("FAIL edge_if_set: got %h, required e4", r); end
    n_cmp++;
    if (irq_req !== 1'b0) begin n_bad++; $display("FAIL edge_req_early: irq_req=%b, required 0", irq_req); end
    tick();
    n_cmp++;
    if (irq_req !== 1'b1) begin n_bad++; $display("FAIL edge_req_latency: irq_req=%b, required 1", irq_req); end
    ack_once();
    n_cmp++;
    if ({vec_valid, vec, ack_onehot, irq_req} !== {1'b1, 16'h0050, 5'b00100, 1'b0}) begin
      n_bad++;
      $display("FAIL edge_dispatch: vv=%b vec=%h ack=%b req=%b, required 1 0050 00100 0",
               vec_valid, vec, ack_onehot, irq_req);
    end
    bus_read(16'hFF0F, r);
    n_cmp++;
    if (r !== 8'hE0) begin n_bad++; $display("FAIL edge_if_clear: got %h, required e0", r); end
    tick();
    n_cmp++;
    if (vec_valid !== 1'b0) begin n_bad++; $display("FAIL strobe_width: vec_valid=%b, required 0", vec_valid); end
    trig = 5'b01000;
    tick();
    trig = '0;
    tick();
    tick();
    n_cmp++;
    if ({irq_req, wake} !== 2'b01) begin
      n_bad++; $display("FAIL ime_cleared_wake: req=%b wake=%b, required 0 1", irq_req, wake);
    end
    bus_write(16'hFF0F, 8'h00);
  endtask

  task automatic test_priority();
    logic [7:0] r;
    bus_write(16'hFF0F, 8'h0A);
    bus_write(16'hFFFF, 8'hFF);
    bus_read(16'hFFFF, r);
    n_cmp++;
    if (r !== 8'h1F) begin n_bad++; $display("FAIL ie_unimpl_bits: got %h, required 1f", r); end
    pulse_reti();
    wait_req(4, "prio_first_req");
    ack_once();
    n_cmp++;
    if ({vec_valid, vec, ack_onehot} !== {1'b1, 16'h0048, 5'b00010}) begin
      n_bad++; $display("FAIL prio_first: vv=%b vec=%h ack=%b, required 1 0048 00010", vec_valid, vec, ack_onehot);
    end
    pulse_reti();
    wait_req(4, "prio_second_req");
    ack_once();
    n_cmp++;
    if ({vec_valid, vec, ack_onehot} !== {1'b1, 16'h0058, 5'b01000}) begin
      n_bad++; $display("FAIL prio_second: vv=%b vec=%h ack=%b, required 1 0058 01000", vec_valid, vec, ack_onehot);
    end
    tick();
  endtask

  task automatic test_ei_delay();
    bus_write(16'hFF0F, 8'h01);
    ei = 1'b1; instr_end = 1'b1;
    tick();
    ei = 1'b0; instr_end = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (irq_req !== 1'b0) begin n_bad++; $display("FAIL ei_same_boundary: irq_req=%b, required 0", irq_req); end
    instr_end = 1'b1;
    tick();
    instr_end = 1'b0;
    n_cmp++;
    if (irq_req !== 1'b0) begin n_bad++; $display("FAIL ei_req_early: irq_req=%b, required 0", irq_req); end
    tick();
    n_cmp++;
    if (irq_req !== 1'b1) begin n_bad++; $display("FAIL ei_next_boundary: irq_req=%b, required 1", irq_req); end
    ack_once();
    n_cmp++;
    if ({vec_valid, vec, ack_onehot} !== {1'b1, 16'h0040, 5'b00001}) begin
      n_bad++; $display("FAIL ei_dispatch: vv=%b vec=%h ack=%b, required 1 0040 00001", vec_valid, vec, ack_onehot);
    end
    tick();
  endtask

  task automatic test_cancel();
    logic [7:0] r;
    bus_write(16'hFF0F, 8'h02);
    pulse_reti();
    wait_req(4, "cancel_req");
    a = 16'hFFFF; din = 8'h00; wr = 1'b1; irq_ack = 1'b1;
    tick();
    wr = 1'b0; irq_ack = 1'b0; a = 16'h0000;
    n_cmp++;
    if ({vec_valid, vec, ack_onehot} !== {1'b1, 16'h0000, 5'b00000}) begin
      n_bad++; $display("FAIL cancel_vec: vv=%b vec=%h ack=%b, required 1 0000 00000", vec_valid, vec, ack_onehot);
    end
    bus_read(16'hFF0F, r);
    n_cmp++;
    if (r !== 8'hE2) begin n_bad++; $display("FAIL cancel_if_kept: got %h, required e2", r); end
    bus_write(16'hFFFF, 8'h1F);
    tick();
    tick();
    n_cmp++;
    if (irq_req !== 1'b0) begin n_bad++; $display("FAIL cancel_ime_cleared: irq_req=%b, required 0", irq_req); end
    bus_write(16'hFF0F, 8'h00);
  endtask

  task automatic test_edge_vs_write();
    logic [7:0] r;
    trig = 5'b00010; a = 16'hFF0F; din = 8'h00; wr = 1'b1;
    tick();
    wr = 1'b0; a = 16'h0000;
    bus_read(16'hFF0F, r);
    n_cmp++;
    if (r !== 8'hE2) begin n_bad++; $display("FAIL event_beats_write: got %h, required e2", r); end
    tick();
    bus_read(16'hFF0F, r);
    n_cmp++;
    if (r !== 8'hE2) begin n_bad++; $display("FAIL edge_held_once: got %h, required e2", r); end
    trig = '0;
    bus_write(16'hFF0F, 8'h00);
  endtask

  task automatic test_level_refire();
    logic [7:0] r;
    bus_write(16'hFFFF, 8'h10);
    trig = 5'b10000;
    tick();
    pulse_reti();
    wait_req(4, "level_req");
    ack_once();
    n_cmp++;
    if ({vec_valid, vec, ack_onehot} !== {1'b1, 16'h0060, 5'b10000}) begin
      n_bad++; $display("FAIL level_dispatch: vv=%b vec=%h ack=%b, required 1 0060 10000", vec_valid, vec, ack_onehot);
    end
    bus_read(16'hFF0F, r);
    n_cmp++;
    if (r !== 8'hE0) begin n_bad++; $display("FAIL level_clear_wins: got %h, required e0", r); end
    for (int k = 0; k < 2; k++) begin
      tick();
      bus_read(16'hFF0F, r);
      n_cmp++;
      if (r !== 8'hF0) begin n_bad++; $display("FAIL level_reset_%0d: got %h, required f0", k, r); end
    end
    n_cmp++;
    if (irq_req !== 1'b0) begin n_bad++; $display("FAIL level_no_rereq: irq_req=%b, required 0", irq_req); end
    trig = '0;
    tick();
    bus_write(16'hFF0F, 8'h00);
    bus_write(16'hFFFF, 8'h1F);
  endtask

  task automatic test_reset_mid_req();
    logic [7:0] r;
    bus_write(16'hFF0F, 8'h04);
    pulse_reti();
    wait_req(4, "midreq_req");
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({irq_req, wake, vec_valid, vec, ack_onehot} !== {3'b000, 16'h0000, 5'b00000}) begin
      n_bad++;
      $display("FAIL midreq_reset_outputs: got %b %b %b %h %b, required 0 0 0 0000 00000",
               irq_req, wake, vec_valid, vec, ack_onehot);
    end
    a = 16'hFF0F; rd = 1'b1;
    #1 r = dout;
    rd = 1'b0; a = 16'h0000;
    n_cmp++;
    if (r !== 8'hE0) begin n_bad++; $display("FAIL midreq_if_read: got %h, required e0", r); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (irq_req !== 1'b0) begin n_bad++; $display("FAIL midreq_after_release: irq_req=%b, required 0", irq_req); end
  endtask

  task automatic test_random(input int cycles);
    logic [7:0] exp_d;
    logic       exp_sel;
    for (int c = 0; c < cycles; c++) begin
      n_cmp++;
      if ({irq_req, wake, vec_valid, vec, ack_onehot} !== {m_requesting, m_wake, m_strobe, m_vec, m_ack}) begin
        n_bad++;
        $display("FAIL rand_outputs @%0d: req=%b wake=%b vv=%b vec=%h ack=%b, required %b %b %b %h %b",
                 c, irq_req, wake, vec_valid, vec, ack_onehot,
                 m_requesting, m_wake, m_strobe, m_vec, m_ack);
      end
      trig      = NI'($urandom);
      ei        = ($urandom_range(0, 15) == 0);
      di        = ($urandom_range(0, 29) == 0);
      reti      = ($urandom_range(0, 9) == 0);
      instr_end = ($urandom_range(0, 2) == 0);
      irq_ack   = ($urandom_range(0, 2) == 0);
      wr        = ($urandom_range(0, 5) == 0);
      rd        = ($urandom_range(0, 1) == 1);
      din       = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       a = 16'hFFFF;
        1:       a = 16'hFF0F;
        default: a = 16'h1234;
      endcase
      #1;
      exp_sel = (a == 16'hFFFF) || (a == 16'hFF0F);
      exp_d   = 8'hFF;
      if (rd && a == 16'hFFFF)      exp_d = {3'b000, m_ie};
      else if (rd && a == 16'hFF0F) exp_d = {3'b111, m_if};
      n_cmp++;
      if ({sel, dout} !== {exp_sel, exp_d}) begin
        n_bad++;
        $display("FAIL rand_read @%0d: sel=%b dout=%h, required %b %h", c, sel, dout, exp_sel, exp_d);
      end
      tick();
    end
    trig = '0; ei = 0; di = 0; reti = 0; instr_end = 0; irq_ack = 0; wr = 0; rd = 0;
  endtask

  initial begin
    test_reset();
    test_edge_dispatch();
    test_priority();
    test_ei_delay();
    test_cancel();
    test_edge_vs_write();
    test_level_refire();
    test_reset_mid_req();
    test_random(4000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
